// File: rtl/uart_rx_framed.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx_framed
// Purpose  : UART receiver with 3-sample majority vote, false-start rejection,
//            parity/framing flags and a valid/ready one-word holding register.
// Revision : 1.0
//==============================================================================
module uart_rx_framed #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] c_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_MID_M1 = CW'(MID - 1);
    localparam logic [CW-1:0] c_MID    = CW'(MID);
    localparam logic [CW-1:0] c_MID_P1 = CW'(MID + 1);
    localparam logic [BW-1:0] c_DLAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_SLAST  = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [1:0]            r_flush;
    logic                  r_prev;
    logic [CW-1:0]         r_sample_ctr;
    logic [BW-1:0]         r_bit_ctr;
    logic                  r_s_early;
    logic                  r_s_mid;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_done;

    logic w_rx_s;
    logic w_start_edge;
    logic w_vote;

    assign w_rx_s       = r_sync[1];
    // r_prev only goes high once the synchroniser holds real line samples,
    // so a line held low through reset cannot fake a falling edge.
    assign w_start_edge = r_prev & ~w_rx_s;
    assign w_vote       = (r_s_early & r_s_mid) | (r_s_early & w_rx_s) | (r_s_mid & w_rx_s);
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync       <= 2'b11;
            r_flush      <= 2'b00;
            r_prev       <= 1'b0;
            r_state      <= S_IDLE;
            r_sample_ctr <= '0;
            r_bit_ctr    <= '0;
            r_s_early    <= 1'b0;
            r_s_mid      <= 1'b0;
            r_data       <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], data_in};
            r_flush <= {r_flush[0], 1'b1};
            r_prev  <= r_flush[1] & w_rx_s;
            r_done  <= 1'b0;
            if (r_state == S_IDLE) begin
                r_sample_ctr <= '0;
                if (w_start_edge) begin
                    r_state   <= S_START;
                    r_bit_ctr <= '0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
            end else begin
                r_sample_ctr <= (r_sample_ctr == c_LAST) ? '0 : r_sample_ctr + 1'b1;
                if (r_sample_ctr == c_MID_M1) r_s_early <= w_rx_s;
                if (r_sample_ctr == c_MID)    r_s_mid   <= w_rx_s;
                if (r_sample_ctr == c_MID_P1) begin
                    case (r_state)
                        S_START: begin
                            r_bit_ctr <= '0;
                            r_state   <= w_vote ? S_IDLE : S_DATA;
                        end
                        S_DATA: begin
                            // LSB-first shift: after DATA_BITS bits the first bit sits at bit 0
                            r_data <= {w_vote, r_data[DATA_BITS-1:1]};
                            if (r_bit_ctr == c_DLAST) begin
                                r_bit_ctr <= '0;
                                r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_ctr <= r_bit_ctr + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            r_perr    <= ((^r_data) ^ w_vote) != (PARITY == 2);
                            r_bit_ctr <= '0;
                            r_state   <= S_STOP;
                        end
                        S_STOP: begin
                            if (!w_vote) begin
                                r_ferr  <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else if (r_bit_ctr == c_SLAST) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_bit_ctr <= r_bit_ctr + 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_done) begin
            if (!valid || ready) begin
                data_out   <= r_data;
                parity_err <= r_perr;
                frame_err  <= r_ferr;
                overrun    <= 1'b0;
                valid      <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
`default_nettype wire
